// File: rtl/seq_presenter.sv
// seq_presenter: plays one round of the memory game's digit sequence.
// A pseudo-random address chain is walked through an external digit ROM.
// Each digit is flashed for ON_CYC cycles, followed by OFF_CYC blank cycles.
// The countdown is then loaded and the block waits for the round outcome.
// Optional build macro: REPLAY_EN -- allows a single re-show of the
// sequence per round from the ARMED state.
module seq_presenter #(
  parameter int DIGIT_W   = 4,
  parameter int ADDR_W    = 5,
  parameter int LVL_W     = 4,
  parameter int LEN_W     = 4,
  parameter int BASE_LEN  = 2,
  parameter int MAX_LEN   = 15,
  parameter int ROM_LAT   = 2,
  parameter int ON_CYC    = 50000000,
  parameter int OFF_CYC   = 50000000,
  parameter int TIME_BASE = 25,
  parameter int TIME_STEP = 5
) (
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [LVL_W-1:0]   i_level,
  input  logic [ADDR_W-1:0]  i_seed,
  input  logic               i_abort,
  input  logic               i_win,
  input  logic               i_lose,
  input  logic               i_time_up,
  input  logic               i_replay,
  input  logic [DIGIT_W-1:0] i_rom_q,
  output logic [ADDR_W-1:0]  o_rom_addr,
  output logic               o_rom_rd,
  output logic [DIGIT_W-1:0] o_disp_digit,
  output logic               o_disp_valid,
  output logic               o_digit_strobe,
  output logic               o_seq_done,
  output logic               o_time_load,
  output logic [7:0]         o_time_val,
  output logic               o_stop,
  output logic               o_busy
);

  // One shared phase counter covers the ROM wait, the on time and the off time.
  localparam int CNT_MAX_A = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > ROM_LAT) ? CNT_MAX_A : ROM_LAT;
  localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHOW,
    S_GAP,
    S_ARMED,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_seed;
  logic [LVL_W-1:0]    r_level;
  logic [DIGIT_W-1:0]  r_prev;
  logic [DIGIT_W-1:0]  r_digit;
  logic [LEN_W-1:0]    r_len;
  logic [7:0]          r_time_val;

  logic                w_start_ok;
  logic                w_fetch_done;
  logic                w_step_addr;
  logic                w_replay_go;
  logic                w_cnt_hold;

`ifdef REPLAY_EN
  logic                r_replay_ok;
`else
  logic                w_unused_replay;
  assign w_unused_replay = i_replay;
`endif

  // Sequence length for a level, clamped to MAX_LEN.
  function automatic logic [LEN_W-1:0] f_len(input logic [LVL_W-1:0] lv);
    logic [15:0] s;
    s = 16'(BASE_LEN) + 16'(lv);
    return (s > 16'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(s);
  endfunction

  // Countdown seed in seconds, computed in 12 bits then saturated to 8.
  function automatic logic [7:0] f_time(input logic [LVL_W-1:0] lv);
    logic [11:0] t;
    t = 12'(TIME_BASE) + 12'(lv) * 12'(TIME_STEP);
    return (t > 12'd255) ? 8'hFF : 8'(t);
  endfunction

  assign o_rom_addr   = r_addr;
  assign o_disp_digit = r_digit;
  assign o_time_val   = r_time_val;

  // State register.
  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_state_next   = r_state;
    w_start_ok     = 1'b0;
    w_fetch_done   = 1'b0;
    w_step_addr    = 1'b0;
    w_replay_go    = 1'b0;
    o_rom_rd       = 1'b0;
    o_disp_valid   = 1'b0;
    o_digit_strobe = 1'b0;
    o_seq_done     = 1'b0;
    o_time_load    = 1'b0;
    o_stop         = 1'b0;
    o_busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_level != '0)) begin
          w_start_ok   = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        o_rom_rd = (r_cnt == '0);
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_W'(ROM_LAT)) begin
          // rom_q answers ROM_LAT cycles after the strobe cycle.
          w_fetch_done = 1'b1;
          w_state_next = S_SHOW;
        end
      end
      S_SHOW: begin
        o_disp_valid   = 1'b1;
        o_digit_strobe = (r_cnt == '0);
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_W'(ON_CYC - 1)) begin
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_W'(OFF_CYC - 1)) begin
          if (r_len == '0) begin
            o_seq_done   = 1'b1;
            o_time_load  = 1'b1;
            w_state_next = S_ARMED;
          end else begin
            w_step_addr  = 1'b1;
            w_state_next = S_FETCH;
          end
        end
      end
      S_ARMED: begin
        if (i_win || i_lose || i_time_up) begin
          w_state_next = S_HALT;
        end else if (i_abort) begin
          w_state_next = S_IDLE;
`ifdef REPLAY_EN
        end else if (i_replay && r_replay_ok) begin
          w_replay_go  = 1'b1;
          w_state_next = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        o_stop       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The phase counter restarts on every state change and idles outside timed states.
  assign w_cnt_hold = (w_state_next != r_state) || (r_state == S_IDLE) ||
                      (r_state == S_ARMED) || (r_state == S_HALT);

  // Phase counter for FETCH, SHOW and GAP.
  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_hold) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Round setup, address chain, digit capture and length bookkeeping.
  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_addr     <= '0;
      r_seed     <= '0;
      r_level    <= '0;
      r_prev     <= '0;
      r_digit    <= '0;
      r_len      <= '0;
      r_time_val <= '0;
    end else begin
      if (w_start_ok) begin
        r_seed     <= i_seed;
        r_level    <= i_level;
        r_addr     <= i_seed;
        r_prev     <= '0;
        r_len      <= f_len(i_level);
        r_time_val <= f_time(i_level);
      end
      if (w_fetch_done) begin
        r_digit <= i_rom_q;
        r_prev  <= i_rom_q;
        r_len   <= r_len - LEN_W'(1);
      end
      if (w_step_addr) begin
        // All operands zero-extended; the sum wraps at 2^ADDR_W.
        r_addr <= r_addr + r_seed + ADDR_W'(r_level) + ADDR_W'(r_prev);
      end
      if (w_replay_go) begin
        r_addr <= r_seed;
        r_prev <= '0;
        r_len  <= f_len(r_level);
      end
    end
  end

`ifdef REPLAY_EN
  // One re-show allowed per round; armed at start, spent on the first replay.
  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_replay_ok <= 1'b0;
    end else if (w_start_ok) begin
      r_replay_ok <= 1'b1;
    end else if (w_replay_go) begin
      r_replay_ok <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_presenter.sv
// Bench for seq_presenter: table-driven rounds, hand-written corner cases
// and randomized rounds checked against an arithmetic model of the chain.
module tb_seq_presenter;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int LAT = 2;

  typedef struct {
    int level;
    int seed;
    int outc;     // 0 win, 1 lose, 2 time_up, 3 abort, 4 win+abort
    bit noise;
    int exp_len;
    int exp_tv;
    int exp_ts;
  } vec_t;

  logic       clock = 1'b0;
  logic       rst;
  logic       start, abort, win, lose, time_up, replay;
  logic [3:0] level;
  logic [4:0] seed;
  logic [3:0] rom_q;

  logic [4:0] rom_addr,     ts_rom_addr;
  logic       rom_rd,       ts_rom_rd;
  logic [3:0] disp_digit,   ts_disp_digit;
  logic       disp_valid,   ts_disp_valid;
  logic       digit_strobe, ts_digit_strobe;
  logic       seq_done,     ts_seq_done;
  logic       time_load,    ts_time_load;
  logic [7:0] time_val,     ts_time_val;
  logic       stop,         ts_stop;
  logic       busy,         ts_busy;

  logic [3:0] rom [32];
  logic [3:0] dpipe [LAT];
  logic       vpipe [LAT];
  logic [3:0] junk;

  int n_vec = 0;
  int n_bad = 0;
  int exp_addr [32];
  int exp_dig  [32];
  int got_addr [32];
  int got_dig  [32];
  vec_t tbl [5];

  always #5 clock = ~clock;

  seq_presenter #(.ON_CYC(ON), .OFF_CYC(OFF), .ROM_LAT(LAT)) dut (
    .i_clock(clock), .i_rst(rst), .i_start(start), .i_level(level), .i_seed(seed),
    .i_abort(abort), .i_win(win), .i_lose(lose), .i_time_up(time_up), .i_replay(replay),
    .i_rom_q(rom_q), .o_rom_addr(rom_addr), .o_rom_rd(rom_rd), .o_disp_digit(disp_digit),
    .o_disp_valid(disp_valid), .o_digit_strobe(digit_strobe), .o_seq_done(seq_done),
    .o_time_load(time_load), .o_time_val(time_val), .o_stop(stop), .o_busy(busy)
  );

  seq_presenter #(.ON_CYC(ON), .OFF_CYC(OFF), .ROM_LAT(LAT), .TIME_STEP(20)) dut_ts (
    .i_clock(clock), .i_rst(rst), .i_start(start), .i_level(level), .i_seed(seed),
    .i_abort(abort), .i_win(win), .i_lose(lose), .i_time_up(time_up), .i_replay(replay),
    .i_rom_q(rom_q), .o_rom_addr(ts_rom_addr), .o_rom_rd(ts_rom_rd),
    .o_disp_digit(ts_disp_digit), .o_disp_valid(ts_disp_valid),
    .o_digit_strobe(ts_digit_strobe), .o_seq_done(ts_seq_done),
    .o_time_load(ts_time_load), .o_time_val(ts_time_val), .o_stop(ts_stop), .o_busy(ts_busy)
  );

  // ROM with LAT cycles of read latency; returns junk when no read is landing.
  always @(posedge clock) begin
    junk     <= 4'($urandom);
    dpipe[0] <= rom[rom_addr];
    vpipe[0] <= rom_rd;
    for (int k = 1; k < LAT; k++) begin
      dpipe[k] <= dpipe[k-1];
      vpipe[k] <= vpipe[k-1];
    end
  end
  assign rom_q = vpipe[LAT-1] ? dpipe[LAT-1] : junk;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    start = 0; abort = 0; win = 0; lose = 0; time_up = 0; replay = 0;
    level = '0; seed = '0;
  endtask

  // Reference chain: address, digit and next address from the round's rules.
  task automatic model(input int lvl, input int sd, input int n);
    int a;
    int p;
    a = sd;
    for (int i = 0; i < n; i++) begin
      exp_addr[i] = a;
      p = int'(rom[a]);
      exp_dig[i] = p;
      a = (a + sd + lvl + p) % 32;
    end
  endtask

  task automatic start_round(input int lvl, input int sd);
    start = 1; level = 4'(lvl); seed = 5'(sd);
    tick();
    drive_idle();
  endtask

  // Watches the sequence from the first FETCH cycle up to the seq_done cycle.
  task automatic check_seq(input bit noise, input int elen, input int etv, input int ets);
    int nrd = 0, ndig = 0, nsd = 0, run = 0, gap = 0, n_stray = 0, n_stop = 0, n_div = 0;
    bit in_gap = 0, busy_ok = 1, done = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (!busy) busy_ok = 0;
      if (stop) n_stop++;
      if (time_load && !seq_done) n_stray++;
      if ({ts_rom_addr, ts_rom_rd, ts_disp_digit, ts_disp_valid, ts_digit_strobe,
           ts_seq_done, ts_time_load, ts_stop, ts_busy} !=
          {rom_addr, rom_rd, disp_digit, disp_valid, digit_strobe,
           seq_done, time_load, stop, busy}) n_div++;
      if (rom_rd) begin
        if (in_gap) chk("gap_len", gap, OFF);
        in_gap = 0;
        if (nrd < 32) got_addr[nrd] = int'(rom_addr);
        nrd++;
      end
      if (digit_strobe) begin
        if (ndig < 32) got_dig[ndig] = int'(disp_digit);
        ndig++;
      end
      if (disp_valid) begin
        run++;
      end else begin
        if (run > 0) begin
          chk("show_len", run, ON);
          run = 0; in_gap = 1; gap = 0;
        end
        if (in_gap) gap++;
      end
      if (seq_done) begin
        nsd++;
        done = 1;
        chk("last_gap_len", gap, OFF);
        chk("time_load", int'(time_load), 1);
        chk("time_val", int'(time_val), etv);
        chk("time_val_step20", int'(ts_time_val), ets);
      end
      if (!done && noise) begin
        start = 1'($urandom); level = 4'($urandom); seed = 5'($urandom);
        win = ($urandom_range(0, 5) == 0); lose = ($urandom_range(0, 5) == 0);
        time_up = ($urandom_range(0, 5) == 0); replay = 1'($urandom);
      end else begin
        drive_idle();
      end
      if (!done) tick();
    end
    chk("seq_done_count", nsd, 1);
    chk("digit_count", ndig, elen);
    chk("read_count", nrd, elen);
    for (int i = 0; i < elen && i < ndig && i < nrd; i++) begin
      chk($sformatf("addr[%0d]", i), got_addr[i], exp_addr[i]);
      chk($sformatf("digit[%0d]", i), got_dig[i], exp_dig[i]);
    end
    chk("busy_in_round", int'(busy_ok), 1);
    chk("stray_time_load", n_stray, 0);
    chk("stop_in_round", n_stop, 0);
    chk("lockstep", n_div, 0);
  endtask

  task automatic finish_round(input int outc);
    case (outc)
      0: win = 1;
      1: lose = 1;
      2: time_up = 1;
      3: abort = 1;
      default: begin win = 1; abort = 1; end
    endcase
    tick();
    drive_idle();
    chk("stop_pulse", int'(stop), int'(outc != 3));
    chk("halt_busy", int'(busy), int'(outc != 3));
    tick();
    chk("stop_width", int'(stop), 0);
    chk("idle_after", int'(busy), 0);
  endtask

  task automatic run_round(input vec_t v);
    model(v.level, v.seed, v.exp_len);
    start_round(v.level, v.seed);
    check_seq(v.noise, v.exp_len, v.exp_tv, v.exp_ts);
    tick();
    chk("armed_busy", int'(busy), 1);
    chk("armed_blank", int'(disp_valid), 0);
    finish_round(v.outc);
    $display("round level=%0d seed=%0d len=%0d time_val=%0d outcome=%0d",
             v.level, v.seed, v.exp_len, v.exp_tv, v.outc);
  endtask

  initial begin
    int hand_addr [3];
    int cnt;
    bit hit;
    bit seen;
    vec_t v;

    drive_idle();
    rst = 0;
    hand_addr = '{3, 10, 24};
    tbl[0] = '{level: 1,  seed: 3,  outc: 0, noise: 0, exp_len: 3,  exp_tv: 30,  exp_ts: 45};
    tbl[1] = '{level: 15, seed: 31, outc: 1, noise: 1, exp_len: 15, exp_tv: 100, exp_ts: 255};
    tbl[2] = '{level: 5,  seed: 0,  outc: 2, noise: 1, exp_len: 7,  exp_tv: 50,  exp_ts: 125};
    tbl[3] = '{level: 13, seed: 17, outc: 4, noise: 0, exp_len: 15, exp_tv: 90,  exp_ts: 255};
    tbl[4] = '{level: 12, seed: 9,  outc: 3, noise: 1, exp_len: 14, exp_tv: 85,  exp_ts: 255};
    for (int a = 0; a < 32; a++) rom[a] = 4'(a);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_rom_rd", int'(rom_rd), 0);
    chk("rst_disp_digit", int'(disp_digit), 0);
    chk("rst_disp_valid", int'(disp_valid), 0);
    chk("rst_strobe", int'(digit_strobe), 0);
    chk("rst_seq_done", int'(seq_done), 0);
    chk("rst_time_load", int'(time_load), 0);
    chk("rst_time_val", int'(time_val), 0);
    chk("rst_stop", int'(stop), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1;
    tick();

    // start with level 0 is ignored
    cnt = 0;
    start = 1; level = 0; seed = 9;
    repeat (5) begin
      tick();
      if (busy || rom_rd) cnt++;
    end
    drive_idle();
    chk("level0_ignored", cnt, 0);

    // Table rounds
    for (int i = 0; i < 5; i++) begin
      run_round(tbl[i]);
      if (i == 0) begin
        for (int k = 0; k < 3; k++) chk($sformatf("l1_addr[%0d]", k), got_addr[k], hand_addr[k]);
      end
    end

    // Abort during the second SHOW
    start_round(3, 5);
    cnt = 0; hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if (digit_strobe) cnt++;
      if (cnt == 2) begin
        hit = 1;
        abort = 1;
      end else begin
        tick();
      end
    end
    tick();
    drive_idle();
    chk("abort_reached", int'(hit), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_blank", int'(disp_valid), 0);
    cnt = 0;
    repeat (20) begin
      tick();
      cnt += int'(stop) + int'(busy);
    end
    chk("abort_quiet", cnt, 0);
    $display("abort during second show handled");
    run_round(tbl[0]);

    // Asynchronous reset in the middle of a GAP
    start_round(4, 2);
    seen = 0; hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if (disp_valid) seen = 1;
      else if (seen) hit = 1;
      if (!hit) tick();
    end
    chk("gap_reached", int'(hit), 1);
    #2;
    rst = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_rom_addr", int'(rom_addr), 0);
    chk("arst_time_val", int'(time_val), 0);
    chk("arst_disp_digit", int'(disp_digit), 0);
    chk("arst_rom_rd", int'(rom_rd), 0);
    tick();
    rst = 1;
    tick();
    chk("arst_idle", int'(busy), 0);
    $display("async reset mid-gap handled");

    // Replay handling
    for (int a = 0; a < 32; a++) rom[a] = 4'($urandom);
    model(2, 7, 4);
    start_round(2, 7);
    check_seq(0, 4, 35, 65);
    tick();
    replay = 1;
    tick();
    replay = 0;
`ifdef REPLAY_EN
    check_seq(0, 4, 35, 65);
    tick();
    replay = 1;
    tick();
    replay = 0;
`endif
    cnt = 0;
    repeat (10) begin
      if (rom_rd || !busy || disp_valid) cnt++;
      tick();
    end
    chk("replay_ignored", cnt, 0);
    finish_round(2);
    $display("replay sequence handled");

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 32; a++) rom[a] = 4'($urandom);
      v.level   = $urandom_range(1, 15);
      v.seed    = $urandom_range(0, 31);
      v.outc    = $urandom_range(0, 4);
      v.noise   = 1;
      v.exp_len = (2 + v.level > 15) ? 15 : 2 + v.level;
      v.exp_tv  = (25 + 5 * v.level > 255) ? 255 : 25 + 5 * v.level;
      v.exp_ts  = (25 + 20 * v.level > 255) ? 255 : 25 + 20 * v.level;
      run_round(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_presenter.md
Name: seq_presenter

Overview:
- Parametrised successor to the game's random-sequence flasher.
- Each round it walks a pseudo-random address chain through the digit ROM and flashes each digit on the display for a programmable on/off time.
- It then arms the response window, loading the countdown value, and waits for the win, lose, time-up or abort outcome.
- Sits between the level/seed logic, the digit ROM, the 7-segment display shifter and the countdown timer. Flash timing uses internal counters, so no external one-second handshake is needed.

Parameters:
- DIGIT_W, 4: displayed digit width; also ROM data width.
- ADDR_W, 5: ROM address width.
- LVL_W, 4: level input width.
- LEN_W, 4: sequence-length counter width.
- BASE_LEN, 2: sequence length = BASE_LEN + level.
- MAX_LEN, 15: clamp for sequence length; must be at most 2^LEN_W-1.
- ROM_LAT, 2: cycles from rom_rd to valid rom_q; minimum 1.
- ON_CYC, 50000000: cycles a digit is shown.
- OFF_CYC, 50000000: blank cycles between digits.
- TIME_BASE, 25: countdown seed, in seconds.
- TIME_STEP, 5: extra seconds per level.

Ports:
- clock, in, 1: system clock.
- rst, in, 1: asynchronous active-low reset.
- start, in, 1: begin a round (level-sampled in IDLE).
- level, in, LVL_W: current level; 0 is invalid.
- seed, in, ADDR_W: random start address.
- abort, in, 1: logout.
- win, in, 1: player succeeded.
- lose, in, 1: player failed.
- time_up, in, 1: countdown expired.
- replay, in, 1: request a re-show of the sequence.
- rom_q, in, DIGIT_W: ROM data.
- rom_addr, out, ADDR_W: ROM address.
- rom_rd, out, 1: one-cycle read strobe.
- disp_digit, out, DIGIT_W: digit to display.
- disp_valid, out, 1: 1 = show disp_digit, 0 = blank.
- digit_strobe, out, 1: one-cycle shift/load pulse for the display.
- seq_done, out, 1: one-cycle pulse when the sequence ends; starts the countdown.
- time_load, out, 1: one-cycle load strobe for the countdown.
- time_val, out, 8: countdown load value, binary.
- stop, out, 1: one-cycle end-of-round pulse.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0, including disp_digit, rom_addr and time_val. Internal address, previous digit, length counter, timer and replay flag are all cleared. Reset asserted mid-round abandons the round immediately.
- IDLE:
  - busy=0, outputs blank.
  - On start=1 with level≠0:
    - latch seed and level;
    - len = min(BASE_LEN+level, MAX_LEN);
    - time_val = min(TIME_BASE + level*TIME_STEP, 255), computed in 12 bits then saturated;
    - rom_addr = seed, prev = 0;
    - replay_ok = 1;
    - go to FETCH.
  - start with level=0 is ignored.
- FETCH:
  - rom_rd=1 on the first cycle only.
  - Stays ROM_LAT cycles, then captures rom_q into disp_digit and goes to SHOW.
- SHOW:
  - disp_valid=1 for exactly ON_CYC cycles; digit_strobe=1 on the first cycle.
  - On entry, len decrements and prev = captured digit.
  - Exit to GAP.
- GAP:
  - disp_valid=0 for exactly OFF_CYC cycles.
  - If len=0: go to ARMED, with seq_done=1 and time_load=1 in the transition cycle.
  - Otherwise: rom_addr = rom_addr + seed + level + prev, modulo 2^ADDR_W with the operands zero-extended; go to FETCH.
- ARMED: waits, with outputs blank. Priority, highest first:
  1. win|lose|time_up → HALT.
  2. abort → IDLE, no stop pulse.
  3. replay, when accepted → restart the sequence: rom_addr = latched seed, prev = 0, len recomputed, replay_ok = 0, go to FETCH. The countdown is not reloaded on the re-show; seq_done and time_load pulse again at its end.
- HALT: stop=1 for one cycle, then IDLE.
- Abort in FETCH, SHOW or GAP: IDLE on the next edge, display blanked, no stop pulse, any pending ROM read discarded.
- win, lose and time_up outside ARMED are ignored.
- start outside IDLE is ignored.
- Replay is deterministic: the same seed, level and ROM contents reproduce the identical digit sequence.

Optional Feature:
- REPLAY_EN, defined: replay is honoured at most once per round (replay_ok).
- REPLAY_EN, undefined: the replay port is ignored; replay_ok logic is not compiled; ARMED reacts only to win, lose, time_up and abort.

Test Plan:
- Level-1 round, seed=3, ON_CYC=4, OFF_CYC=2, ROM_LAT=2, rom[a]=a[3:0]:
  - 3 digits shown at addresses 3, 10, 24;
  - digit_strobe pulses 3 times;
  - seq_done and time_load pulse together once, with time_val=30;
  - win in ARMED → stop pulse 1 cycle → IDLE.
- Level-15, seed=31, BASE_LEN=2, TIME_STEP=20:
  - len clamps to 15 digits;
  - address wraps modulo 32;
  - time_val=255 (saturated).
- Abort asserted during the 2nd SHOW:
  - busy falls the next cycle; disp_valid=0; stop never pulses;
  - a new start succeeds afterwards.
- rst pulled low mid-GAP (asynchronous, between edges): all outputs 0 immediately; FSM in IDLE after release.
- With REPLAY_EN defined:
  - replay in ARMED re-shows the identical digit list and seq_done pulses again;
  - a second replay is ignored;
  - time_up → stop.
- With REPLAY_EN undefined: replay has no effect. start with level=0 is ignored (busy stays 0). win before the sequence ends is ignored.
